pipeline_hazard_ctrl: RTL and testbench

Hazard and stall scheduler for the five-stage MIPS pipeline. Every cycle it decides which pipeline registers hold, which flush, and which operands forward. It also runs a small state machine that stretches the memory stage while a multi-cycle data memory completes an access. Its stall and flush outputs drive the pipeline control registers and the datapath register enables.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv | 76 +++++++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl_pkg
// Purpose  : Shared definitions for the five-stage pipeline hazard unit:
//            forwarding-select codes, memory wait state encoding and a
//            register-match helper that never matches register 0.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Register 0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic src_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_mem_wait_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mem_wait_fsm
// Purpose  : Stretches the memory stage while a multi-cycle data memory
//            completes, abandoning the access after MEM_TIMEOUT cycles.
// Ports    : clk, reset (sync, active-low)
//            memaccess   - load or store present in M
//            mem_ready   - data memory completion strobe
//            memstall    - hold the whole pipeline this cycle
//            mem_timeout - sticky flag, set when an access is abandoned
// Revision : 1.0 - initial release
// ============================================================================
module mem_wait_fsm
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic memaccess,
  input  logic mem_ready,
  output logic memstall,
  output logic mem_timeout
);

  localparam logic [15:0] LAST_CNT = 16'(MEM_TIMEOUT - 1);

  mem_state_t  state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic        timeout_nx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 16'd0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      mem_timeout <= timeout_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    timeout_nx = mem_timeout;
    memstall   = 1'b0;
    case (state)
      IDLE: begin
        // The first cycle of a slow access already stalls and counts as 1.
        if (memaccess && !mem_ready) begin
          memstall = 1'b1;
          state_nx = WAIT;
          cnt_nx   = 16'd1;
        end
      end
      WAIT: begin
        // Completion wins over timeout when both land in the same cycle.
        if (mem_ready) begin
          state_nx = IDLE;
        end else if (cnt == LAST_CNT) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          memstall = 1'b1;
          cnt_nx   = cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!reset) memstall = 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Hazard and stall scheduler for the five-stage MIPS pipeline.
//            Computes forwarding selects, load-use / branch bubbles, branch
//            flushes and full-pipeline holds for slow data memory accesses.
// Ports    : clk, reset (sync, active-low)
//            rsd/rtd, rse/rte           - source registers in D and E
//            writerege/m/w, regwritee/m/w - destinations and write enables
//            memtorege/m, memwritem     - load/store indicators
//            branchd, pcsrcd            - branch in D, branch taken
//            mem_ready                  - data memory completion strobe
//            stallf..stallw, flushd/e   - pipeline register controls
//            forwardad/bd, forwardae/be - forwarding selects
//            mem_timeout, stall_cycles  - status
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsd,
  input  logic [4:0]       rtd,
  input  logic [4:0]       rse,
  input  logic [4:0]       rte,
  input  logic [4:0]       writerege,
  input  logic [4:0]       writeregm,
  input  logic [4:0]       writeregw,
  input  logic             regwritee,
  input  logic             regwritem,
  input  logic             regwritew,
  input  logic             memtorege,
  input  logic             memtoregm,
  input  logic             memwritem,
  input  logic             branchd,
  input  logic             pcsrcd,
  input  logic             mem_ready,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             stallm,
  output logic             stallw,
  output logic             flushd,
  output logic             flushe,
  output logic             forwardad,
  output logic             forwardbd,
  output logic [1:0]       forwardae,
  output logic [1:0]       forwardbe,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  logic lwstall;
  logic branchstall;
  logic memaccess;
  logic memstall;

  assign lwstall     = memtorege && (src_match(rsd, rte) || src_match(rtd, rte));
  assign branchstall = branchd &&
                       ((regwritee && (src_match(rsd, writerege) || src_match(rtd, writerege))) ||
                        (memtoregm && (src_match(rsd, writeregm) || src_match(rtd, writeregm))));
  assign memaccess   = memtoregm || memwritem;

  mem_wait_fsm #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_fsm (
    .clk         (clk),
    .reset       (reset),
    .memaccess   (memaccess),
    .mem_ready   (mem_ready),
    .memstall    (memstall),
    .mem_timeout (mem_timeout)
  );

  always_comb begin
    stallf    = 1'b0;
    stalld    = 1'b0;
    stalle    = 1'b0;
    stallm    = 1'b0;
    stallw    = 1'b0;
    flushd    = 1'b0;
    flushe    = 1'b0;
    forwardad = 1'b0;
    forwardbd = 1'b0;
    forwardae = FWD_RF;
    forwardbe = FWD_RF;
    if (reset) begin
      // M is younger than W, so its result takes priority.
      if (regwritem && src_match(rse, writeregm))      forwardae = FWD_MEM;
      else if (regwritew && src_match(rse, writeregw)) forwardae = FWD_WB;
      if (regwritem && src_match(rte, writeregm))      forwardbe = FWD_MEM;
      else if (regwritew && src_match(rte, writeregw)) forwardbe = FWD_WB;
      forwardad = regwritem && src_match(rsd, writeregm);
      forwardbd = regwritem && src_match(rtd, writeregm);

      if (memstall) begin
        stallf = 1'b1;
        stalld = 1'b1;
        stalle = 1'b1;
        stallm = 1'b1;
        stallw = 1'b1;
      end else if (lwstall || branchstall) begin
        // Both hazards together still cost only one bubble.
        stallf = 1'b1;
        stalld = 1'b1;
        flushe = 1'b1;
      end else begin
        flushd = pcsrcd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (stallf && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed-vector bench for pipeline_hazard_ctrl. The driver
//            pushes the hand-computed response for each applied vector into
//            a queue; a monitor pops and compares it mid-cycle.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] rsd, rtd, rse, rte, writerege, writeregm, writeregw;
  logic regwritee, regwritem, regwritew, memtorege, memtoregm, memwritem;
  logic branchd, pcsrcd, mem_ready;
  logic stallf, stalld, stalle, stallm, stallw, flushd, flushe;
  logic forwardad, forwardbd;
  logic [1:0] forwardae, forwardbe;
  logic mem_timeout;
  logic [TB_CNT_W-1:0] stall_cycles;

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk (clk), .reset (reset),
    .rsd (rsd), .rtd (rtd), .rse (rse), .rte (rte),
    .writerege (writerege), .writeregm (writeregm), .writeregw (writeregw),
    .regwritee (regwritee), .regwritem (regwritem), .regwritew (regwritew),
    .memtorege (memtorege), .memtoregm (memtoregm), .memwritem (memwritem),
    .branchd (branchd), .pcsrcd (pcsrcd), .mem_ready (mem_ready),
    .stallf (stallf), .stalld (stalld), .stalle (stalle), .stallm (stallm), .stallw (stallw),
    .flushd (flushd), .flushe (flushe),
    .forwardad (forwardad), .forwardbd (forwardbd),
    .forwardae (forwardae), .forwardbe (forwardbe),
    .mem_timeout (mem_timeout), .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [12:0]         ctrl;
    logic                mto;
    logic [TB_CNT_W-1:0] sc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   pass_cnt = 0;
  int   chk_cnt  = 0;
  logic [TB_CNT_W-1:0] model_sc = '0;
  logic [12:0] act_ctrl;

  // {stallf,stalld,stalle,stallm,stallw, flushd,flushe, forwardad,forwardbd, forwardae, forwardbe}
  assign act_ctrl = {stallf, stalld, stalle, stallm, stallw, flushd, flushe,
                     forwardad, forwardbd, forwardae, forwardbe};

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk_cnt++;
      if (act_ctrl === mon_e.ctrl) pass_cnt++;
      else $display("FAIL %s ctrl: got %b, expected %b", mon_e.name, act_ctrl, mon_e.ctrl);
      chk_cnt++;
      if (mem_timeout === mon_e.mto) pass_cnt++;
      else $display("FAIL %s mem_timeout: got %b, expected %b", mon_e.name, mem_timeout, mon_e.mto);
      chk_cnt++;
      if (stall_cycles === mon_e.sc) pass_cnt++;
      else $display("FAIL %s stall_cycles: got %0d, expected %0d", mon_e.name, stall_cycles, mon_e.sc);
    end
  end

  task automatic clear_inputs();
    rsd = 5'd0; rtd = 5'd0; rse = 5'd0; rte = 5'd0;
    writerege = 5'd0; writeregm = 5'd0; writeregw = 5'd0;
    regwritee = 1'b0; regwritem = 1'b0; regwritew = 1'b0;
    memtorege = 1'b0; memtoregm = 1'b0; memwritem = 1'b0;
    branchd = 1'b0; pcsrcd = 1'b0; mem_ready = 1'b0;
  endtask

  // Queue the expected response for the inputs currently applied, then
  // advance one cycle. The stall counter expectation tracks the stallf
  // values given in earlier vectors, saturating at all-ones.
  task automatic step(input string nm, input logic [4:0] st, input logic [1:0] fl,
                      input logic [1:0] fdb, input logic [1:0] fae, input logic [1:0] fbe,
                      input logic mto);
    exp_t e;
    e.name = nm;
    e.ctrl = {st, fl, fdb, fae, fbe};
    e.mto  = mto;
    e.sc   = model_sc;
    sb_q.push_back(e);
    if (!reset) model_sc = '0;
    else if (st[4] && (model_sc != {TB_CNT_W{1'b1}})) model_sc = model_sc + 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    clear_inputs();
    @(posedge clk); #1;

    // Reset forces every output low even with hazards present
    rse = 5'd5; writeregm = 5'd5; regwritem = 1'b1;
    memtorege = 1'b1; rte = 5'd8; rsd = 5'd8; branchd = 1'b1; pcsrcd = 1'b1;
    step("reset_gate",    5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // Forwarding priority
    clear_inputs(); reset = 1'b1;
    rse = 5'd5; writeregm = 5'd5; writeregw = 5'd5; regwritem = 1'b1; regwritew = 1'b1;
    step("fwd_mem_prio",  5'b00000, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
    regwritem = 1'b0;
    step("fwd_wb",        5'b00000, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0);
    rse = 5'd0; rte = 5'd5;
    step("fwd_rse_zero",  5'b00000, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
    rsd = 5'd7; rtd = 5'd9; writeregm = 5'd7; regwritem = 1'b1;
    step("fwd_decode",    5'b00000, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0);

    // Register 0 on every field: nothing may match
    clear_inputs();
    regwritee = 1'b1; regwritem = 1'b1; regwritew = 1'b1; memtorege = 1'b1; branchd = 1'b1;
    step("zero_reg",      5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // Load-use bubble
    clear_inputs();
    memtorege = 1'b1; rte = 5'd8; rsd = 5'd8;
    step("lw_stall",      5'b11000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    memtorege = 1'b0;
    step("lw_released",   5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // Branch bubble suppresses the taken-branch flush, then flush once clear
    clear_inputs();
    branchd = 1'b1; regwritee = 1'b1; writerege = 5'd3; rtd = 5'd3; pcsrcd = 1'b1;
    step("br_stall",      5'b11000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    regwritee = 1'b0;
    step("br_flush",      5'b00000, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0);

    // Load-use and branch hazard together: one bubble
    clear_inputs();
    memtorege = 1'b1; rte = 5'd4; rsd = 5'd4; branchd = 1'b1; regwritee = 1'b1; writerege = 5'd4;
    step("lw_and_br",     5'b11000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);

    // 4-cycle load: 3 held cycles; completion coincides with the last count
    clear_inputs();
    memtoregm = 1'b1;
    step("mem_wait1",     5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step("mem_wait2",     5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step("mem_wait3",     5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    mem_ready = 1'b1;
    step("mem_done",      5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    memtoregm = 1'b0;
    step("ready_idle",    5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // Store that never completes: abandoned after MEM_TIMEOUT-1 held cycles
    mem_ready = 1'b0; memwritem = 1'b1;
    step("to_wait1",      5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step("to_wait2",      5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step("to_wait3",      5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    step("to_release",    5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    memwritem = 1'b0;
    step("to_flag",       5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    step("to_sticky",     5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

    // Reset in the second WAIT cycle abandons without a timeout
    memtoregm = 1'b1;
    step("rw_idle",       5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    step("rw_wait1",      5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    reset = 1'b0;
    step("rw_reset",      5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    reset = 1'b1; memtoregm = 1'b0;
    step("rw_after",      5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // 2-cycle load: exactly one held cycle, starting from IDLE
    memtoregm = 1'b1;
    step("mem2_wait",     5'b11111, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    mem_ready = 1'b1;
    step("mem2_done",     5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    clear_inputs();
    step("mem2_after",    5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    // Drive the stall counter into saturation
    memtorege = 1'b1; rte = 5'd2; rsd = 5'd2;
    for (int i = 0; i < 16; i++)
      step("sat_stall",   5'b11000, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    clear_inputs();
    step("sat_hold",      5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    @(negedge clk); #1;
    if (sb_q.size() != 0) begin
      chk_cnt++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
